// File: rtl/stage4_mem_pkg.sv
// rtl/stage4_mem_pkg.sv - shared bus widths, bus layout and load-op encodings for the MEM stage
package stage4_mem_pkg;

  localparam int WIDTH_ES_TO_MS_BUS = 74;
  localparam int WIDTH_MS_TO_WS_BUS = 70;
  localparam int WIDTH_MS_TO_DS_BUS = 39;

  // ld_op[2] selects zero-extension; unlisted codes fall back to a word load
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b101;
  localparam logic [2:0] LD_HU = 3'b110;

  typedef enum logic {
    BUF_WAIT = 1'b0,
    BUF_HAVE = 1'b1
  } buf_state_e;

  // Packed MSB-first, so the field order matches the EX->MEM bit layout
  typedef struct packed {
    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic [31:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/stage4_mem_load_extend.sv
// rtl/stage4_mem_load_extend.sv - selects the addressed byte/half of a load word and extends it
module stage4_mem_load_extend
  import stage4_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // off[0] is ignored for halfwords; misalignment is trapped before MEM
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    case (ld_op)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'h000000, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/stage4_mem.sv
// rtl/stage4_mem.sv - pipeline MEM stage: holds one instruction, waits for load data, forwards to WB and ID
module stage4_mem
  import stage4_mem_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          es_to_ms_valid,
  output logic                          ms_allow_in,
  input  logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus,
  input  logic                          ws_allow_in,
  output logic                          ms_to_ws_valid,
  output logic [WIDTH_MS_TO_WS_BUS-1:0] ms_to_ws_bus,
  output logic [WIDTH_MS_TO_DS_BUS-1:0] ms_to_ds_bus,
  input  logic                          data_sram_data_ok,
  input  logic [31:0]                   data_sram_rdata
);

  es_to_ms_t   bus_r;
  logic        ms_valid;
  buf_state_e  buf_state;
  buf_state_e  buf_next;
  logic        buf_fill;
  logic [31:0] rdata_buf;
  logic        ms_ready_go;
  logic        ld_pending;
  logic [31:0] load_data;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign ms_ready_go    = !bus_r.res_from_mem || data_sram_data_ok || (buf_state == BUF_HAVE);
  assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
      bus_r    <= '0;
    end else if (ms_allow_in) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        bus_r <= es_to_ms_t'(es_to_ms_bus);
      end
    end
  end

  // Response buffer keeps load data that arrived while WB was not accepting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_state <= BUF_WAIT;
      rdata_buf <= 32'h0;
    end else begin
      buf_state <= buf_next;
      if (buf_fill) begin
        rdata_buf <= data_sram_rdata;
      end
    end
  end

  always_comb begin
    buf_next = buf_state;
    buf_fill = 1'b0;
    case (buf_state)
      BUF_WAIT: begin
        if (data_sram_data_ok && ms_valid && bus_r.res_from_mem && !ws_allow_in) begin
          buf_next = BUF_HAVE;
          buf_fill = 1'b1;
        end
      end
      BUF_HAVE: begin
        if (ms_to_ws_valid && ws_allow_in) begin
          buf_next = BUF_WAIT;
        end
      end
      default: buf_next = BUF_WAIT;
    endcase
  end

  assign load_data = (buf_state == BUF_HAVE) ? rdata_buf : data_sram_rdata;

  stage4_mem_load_extend u_load_extend (
    .rdata  (load_data),
    .off    (bus_r.alu_result[1:0]),
    .ld_op  (bus_r.ld_op),
    .result (load_result)
  );

  assign final_result = bus_r.res_from_mem ? load_result : bus_r.alu_result;
  assign ld_pending   = ms_valid && bus_r.res_from_mem && !ms_ready_go;

  assign ms_to_ws_bus = {final_result, bus_r.dest, bus_r.gr_we, bus_r.pc};
  assign ms_to_ds_bus = {ld_pending, ms_valid && bus_r.gr_we, bus_r.dest, final_result};

endmodule

// File: tb/tb_stage4_mem.sv
// tb/tb_stage4_mem.sv - directed self-checking bench for the MEM stage
module tb_stage4_mem;

  logic        clk;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allow_in;
  logic [73:0] es_to_ms_bus;
  logic        ws_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int total = 0;
  int bad   = 0;

  stage4_mem dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allow_in       (ms_allow_in),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allow_in       (ws_allow_in),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [73:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic rfm, input logic [2:0] op);
    return {op, rfm, alu, dest, we, pc};
  endfunction

  function automatic logic [69:0] ws(input logic [31:0] res, input logic [4:0] dest,
                                     input logic we, input logic [31:0] pc);
    return {res, dest, we, pc};
  endfunction

  function automatic logic [38:0] ds(input logic pend, input logic we, input logic [4:0] dest,
                                     input logic [31:0] wdata);
    return {pend, we, dest, wdata};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_ds(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One load whose data arrives in its first MEM cycle with WB ready
  task automatic ld_case(input string tag, input logic [2:0] op, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [31:0] exp);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h1c000100, 1'b1, 5'd7, {30'h00000400, off}, 1'b1, op);
    tick();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    chk1({tag, "_valid"}, ms_to_ws_valid, 1'b1);
    chk(tag, ms_to_ws_bus, ws(exp, 5'd7, 1'b1, 32'h1c000100));
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    ws_allow_in       = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    chk1("rst_allow", ms_allow_in, 1'b1);
    chk1("rst_valid", ms_to_ws_valid, 1'b0);
    chk("rst_ws_bus", ms_to_ws_bus, 70'h0);
    chk_ds("rst_ds_bus", ms_to_ds_bus, 39'h0);
    tick();
    tick();
    reset = 1'b0;

    // ALU op passes through in one cycle
    ws_allow_in    = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h1c000000, 1'b1, 5'd3, 32'h12345678, 1'b0, 3'b000);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk1("alu_valid", ms_to_ws_valid, 1'b1);
    chk("alu_ws_bus", ms_to_ws_bus, ws(32'h12345678, 5'd3, 1'b1, 32'h1c000000));
    chk_ds("alu_ds_bus", ms_to_ds_bus, ds(1'b0, 1'b1, 5'd3, 32'h12345678));
    tick();
    chk1("alu_gone", ms_to_ws_valid, 1'b0);
    chk1("alu_allow", ms_allow_in, 1'b1);

    // Load extraction
    ld_case("ld_b",   3'b001, 2'd3, 32'h80FF0000, 32'hFFFFFF80);
    ld_case("ld_bu",  3'b101, 2'd3, 32'h80FF0000, 32'h00000080);
    ld_case("ld_h",   3'b010, 2'd2, 32'h80FF0000, 32'hFFFF80FF);
    ld_case("ld_hu",  3'b110, 2'd2, 32'h80FF0000, 32'h000080FF);
    ld_case("ld_h_o3", 3'b010, 2'd3, 32'h80FF0000, 32'hFFFF80FF);
    ld_case("ld_w",   3'b000, 2'd0, 32'h80FF0000, 32'h80FF0000);
    ld_case("ld_b_o0", 3'b001, 2'd0, 32'h1234567F, 32'h0000007F);
    ld_case("ld_b_o1", 3'b001, 2'd1, 32'h1234A67F, 32'hFFFFFFA6);
    ld_case("ld_hu_o0", 3'b110, 2'd0, 32'h1234F67F, 32'h0000F67F);
    ld_case("ld_bad_op", 3'b011, 2'd1, 32'hCAFEBABE, 32'hCAFEBABE);

    // Load with data_ok three cycles late; EX holds the next op meanwhile
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h1c000200, 1'b1, 5'd9, 32'h00002000, 1'b1, 3'b000);
    tick();
    es_to_ms_bus   = mk(32'h1c000204, 1'b1, 5'd10, 32'h55AA55AA, 1'b0, 3'b000);
    data_sram_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("stall_valid", ms_to_ws_valid, 1'b0);
      chk1("stall_pending", ms_to_ds_bus[38], 1'b1);
      chk1("stall_allow", ms_allow_in, 1'b0);
      chk("stall_dest", {65'h0, ms_to_ds_bus[36:32]}, {65'h0, 5'd9});
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEADBEEF;
    #1;
    chk1("late_valid", ms_to_ws_valid, 1'b1);
    chk1("late_allow", ms_allow_in, 1'b1);
    chk1("late_pending", ms_to_ds_bus[38], 1'b0);
    chk("late_ws_bus", ms_to_ws_bus, ws(32'hDEADBEEF, 5'd9, 1'b1, 32'h1c000200));
    tick();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    chk1("held_op_valid", ms_to_ws_valid, 1'b1);
    chk("held_op_bus", ms_to_ws_bus, ws(32'h55AA55AA, 5'd10, 1'b1, 32'h1c000204));
    tick();

    // data_ok while WB is blocked: response must be buffered
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h1c000300, 1'b1, 5'd11, 32'h00003000, 1'b1, 3'b000);
    tick();
    es_to_ms_valid    = 1'b0;
    ws_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEADBEEF;
    #1;
    chk1("buf_valid0", ms_to_ws_valid, 1'b1);
    chk1("buf_allow0", ms_allow_in, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0BADF00D;
    #1;
    chk1("buf_valid1", ms_to_ws_valid, 1'b1);
    chk("buf_ws_bus1", ms_to_ws_bus, ws(32'hDEADBEEF, 5'd11, 1'b1, 32'h1c000300));
    tick();
    ws_allow_in = 1'b1;
    #1;
    chk("buf_ws_bus2", ms_to_ws_bus, ws(32'hDEADBEEF, 5'd11, 1'b1, 32'h1c000300));
    chk1("buf_allow2", ms_allow_in, 1'b1);
    tick();
    chk1("buf_gone", ms_to_ws_valid, 1'b0);

    // Next load must wait again, proving the buffer emptied
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h1c000304, 1'b1, 5'd12, 32'h00003004, 1'b1, 3'b000);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk1("rebuf_valid", ms_to_ws_valid, 1'b0);
    chk1("rebuf_pending", ms_to_ds_bus[38], 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h13579BDF;
    #1;
    chk("rebuf_ws_bus", ms_to_ws_bus, ws(32'h13579BDF, 5'd12, 1'b1, 32'h1c000304));
    tick();
    data_sram_data_ok = 1'b0;

    // Back-to-back ALU ops, one retiring per cycle
    for (int i = 0; i < 5; i++) begin
      logic [31:0] pc_p;
      logic [31:0] alu_p;
      logic [4:0]  dest_p;
      logic        we_p;
      if (i < 4) begin
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1c000400 + 32'(4 * i), (i % 2) == 0, 5'(i + 1),
                            32'hA0000000 + 32'(i * 32'h111), 1'b0, 3'b000);
      end else begin
        es_to_ms_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        pc_p   = 32'h1c000400 + 32'(4 * (i - 1));
        alu_p  = 32'hA0000000 + 32'((i - 1) * 32'h111);
        dest_p = 5'(i);
        we_p   = ((i - 1) % 2) == 0;
        chk1("b2b_valid", ms_to_ws_valid, 1'b1);
        chk1("b2b_allow", ms_allow_in, 1'b1);
        chk("b2b_ws_bus", ms_to_ws_bus, ws(alu_p, dest_p, we_p, pc_p));
        chk_ds("b2b_ds_bus", ms_to_ds_bus, ds(1'b0, we_p, dest_p, alu_p));
      end
      tick();
    end
    chk1("b2b_drained", ms_to_ws_valid, 1'b0);

    // Reset during a buffered load stall
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h1c000500, 1'b1, 5'd13, 32'h00004001, 1'b1, 3'b001);
    tick();
    es_to_ms_valid    = 1'b0;
    ws_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000AB00;
    #1;
    chk("rst_ld_ws_bus", ms_to_ws_bus, ws(32'hFFFFFFAB, 5'd13, 1'b1, 32'h1c000500));
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    chk1("rst_ld_held", ms_to_ws_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk1("arst_allow", ms_allow_in, 1'b1);
    chk1("arst_valid", ms_to_ws_valid, 1'b0);
    chk("arst_ws_bus", ms_to_ws_bus, 70'h0);
    chk_ds("arst_ds_bus", ms_to_ds_bus, 39'h0);
    tick();
    reset       = 1'b0;
    ws_allow_in = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h1c000600, 1'b1, 5'd14, 32'h00005002, 1'b1, 3'b110);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk1("post_rst_valid", ms_to_ws_valid, 1'b0);
    chk1("post_rst_pending", ms_to_ds_bus[38], 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE1234;
    #1;
    chk("post_rst_ws_bus", ms_to_ws_bus, ws(32'h0000CAFE, 5'd14, 1'b1, 32'h1c000600));
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    chk1("post_rst_gone", ms_to_ws_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
